// File: rtl/i2c_slave.sv
// I2C responder at a fixed 7-bit address with synchronised, glitch-filtered SCL/SDA.
// Define I2C_SLAVE_STRETCH_EN to add tx_valid and hold SCL low until each read byte arrives.
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b0011011,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk_50,
  input  logic       rst,
  inout  wire        SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
`ifdef I2C_SLAVE_STRETCH_EN
  input  logic       tx_valid,
`endif
  output logic       tx_req,
  output logic       rw,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck, StIgnore
  } state_e;

  // Bit 0 carries SCL, bit 1 carries SDA through the input path.
  logic [1:0]      sync1_q, sync2_q, filt_q, filt_prev_q;
  logic [CntW-1:0] flt_cnt_q [2];

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;
  logic       load_tx;
`ifdef I2C_SLAVE_STRETCH_EN
  logic       stretch_q, stretch_d;
`endif

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_in;

  assign scl_f    = filt_q[0];
  assign sda_f    = filt_q[1];
  assign scl_p    = filt_prev_q[0];
  assign sda_p    = filt_prev_q[1];
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;
  assign byte_in  = {shift_q, sda_f};

  always_ff @(posedge clk_50) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      filt_prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= {SDA, SCL};
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      // A level is accepted only after FILTER_LEN consecutive differing samples.
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == CntW'(FILTER_LEN - 1)) begin
          filt_q[i]    <= sync2_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    sda_low_d   = sda_low_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rw_d        = rw_q;
    busy_d      = busy_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    tx_req      = 1'b0;
    load_tx     = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
    stretch_d   = stretch_q;
`endif
    if (start_c) begin
      state_d     = StAddr;
      bit_cnt_d   = '0;
      sda_low_d   = 1'b0;
      busy_d      = 1'b0;
      start_det_d = 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
      stretch_d   = 1'b0;
`endif
    end else if (stop_c) begin
      state_d    = StIdle;
      sda_low_d  = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
      stretch_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StIgnore: sda_low_d = 1'b0;
        StAddr: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_d = StAddrAck;
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        // First fall starts the ACK, the fall ending the 9th pulse releases it.
        StAddrAck, StWrAck: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              if (state_q == StAddrAck && rw_q) begin
                state_d = StRdData;
                load_tx = 1'b1;
              end else begin
                state_d = StWrData;
              end
            end
          end
        end
        StWrData: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              state_d    = StWrAck;
            end
          end
        end
        StRdData: begin
`ifdef I2C_SLAVE_STRETCH_EN
          if (stretch_q) begin
            if (tx_valid) begin
              stretch_d  = 1'b0;
              tx_shift_d = tx_data[6:0];
              sda_low_d  = ~tx_data[7];
            end
          end else
`endif
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              state_d   = StRdAck;
            end else begin
              sda_low_d  = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 1'b1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise && sda_f) begin
            state_d = StIgnore;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            state_d = StRdData;
            load_tx = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (load_tx) begin
      tx_req    = 1'b1;
      bit_cnt_d = '0;
`ifdef I2C_SLAVE_STRETCH_EN
      stretch_d = 1'b1;
      sda_low_d = 1'b0;
`else
      tx_shift_d = tx_data[6:0];
      sda_low_d  = ~tx_data[7];
`endif
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_shift_q  <= '0;
      sda_low_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      stretch_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      sda_low_q   <= sda_low_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
`ifdef I2C_SLAVE_STRETCH_EN
      stretch_q   <= stretch_d;
`endif
    end
  end

  assign SDA = sda_low_q ? 1'b0 : 1'bz;
`ifdef I2C_SLAVE_STRETCH_EN
  assign SCL = stretch_q ? 1'b0 : 1'bz;
`else
  assign SCL = 1'bz;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rw        = rw_q;
  assign busy      = busy_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master drives directed transfers; a scoreboard
// process checks written bytes (rx_valid) and bytes read back from the bus.
module tb_i2c_slave;

  localparam int Q = 40;  // clk_50 cycles per quarter SCL period

  logic       clk_50 = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  wire        scl, sda;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_req, rw, busy, start_det, stop_det;
`ifdef I2C_SLAVE_STRETCH_EN
  logic       tx_valid;
`endif

  pullup (scl);
  pullup (sda);
  assign scl = m_scl ? 1'bz : 1'b0;
  assign sda = m_sda ? 1'bz : 1'b0;

  always #10 clk_50 = ~clk_50;

  i2c_slave dut (
    .clk_50   (clk_50),
    .rst      (rst),
    .SCL      (scl),
    .SDA      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
`ifdef I2C_SLAVE_STRETCH_EN
    .tx_valid (tx_valid),
`endif
    .tx_req   (tx_req),
    .rw       (rw),
    .busy     (busy),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_rxv = 0, n_txreq = 0, n_start = 0, n_stop = 0, n_busy = 0;
  int n_sda_drv = 0, n_scl_drv = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] got_rd[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_rxv = 0; n_txreq = 0; n_start = 0; n_stop = 0; n_busy = 0;
    n_sda_drv = 0; n_scl_drv = 0;
  endtask

  // Scoreboard / monitor
  always @(negedge clk_50) begin
    if (rx_valid) begin
      n_rxv++;
      if (exp_rx.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h, expected no write byte", rx_data);
      end else begin
        chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
      end
    end
    if (got_rd.size() != 0) begin
      if (exp_rd.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read byte", got_rd.pop_front());
      end else begin
        chk("rd_byte", {24'd0, got_rd.pop_front()}, {24'd0, exp_rd.pop_front()});
      end
    end
    if (tx_req) n_txreq++;
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (busy) n_busy++;
    if (m_sda && sda === 1'b0) n_sda_drv++;
    if (m_scl && scl === 1'b0) n_scl_drv++;
  end

`ifdef I2C_SLAVE_STRETCH_EN
  initial begin
    tx_valid = 1'b0;
    forever begin
      @(negedge clk_50);
      if (tx_req) begin
        repeat (50) @(negedge clk_50);
        tx_valid = 1'b1;
        @(negedge clk_50);
        tx_valid = 1'b0;
      end
    end
  end
`endif

  task automatic qwait();
    repeat (Q) @(posedge clk_50);
  endtask

  task automatic scl_high();
    int t = 0;
    m_scl = 1'b1;
    while (scl !== 1'b1 && t < 2000) begin
      @(posedge clk_50);
      t++;
    end
    if (t >= 2000) chk("scl_release_timeout", t, 0);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qwait();
    scl_high(); qwait();
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qwait();
    scl_high(); qwait();
    m_sda = 1'b1; qwait();
  endtask

  task automatic put_bit(input logic b, input logic glitch);
    m_sda = b;
    if (glitch) begin
      repeat (Q / 2) @(posedge clk_50);
      m_scl = 1'b1;
      @(posedge clk_50);
      m_scl = 1'b0;
      repeat (Q / 2) @(posedge clk_50);
    end else begin
      qwait();
    end
    scl_high(); qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; qwait();
    scl_high();
    repeat (Q / 2) @(posedge clk_50);
    @(negedge clk_50);
    b = sda;
    repeat (Q / 2) @(posedge clk_50);
    m_scl = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i], glitch);
    get_bit(ack);
  endtask

  task automatic read_byte(input logic [7:0] next_tx, input logic nack);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    got_rd.push_back(d);
    tx_data = next_tx;
    put_bit(nack, 1'b0);
  endtask

  initial begin
    #1_600_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic ack;
    logic b;
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
    repeat (5) @(posedge clk_50);
    @(negedge clk_50);
    chk("reset_rx_data", {24'd0, rx_data}, 32'h0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'h0);
    chk("reset_tx_req", {31'd0, tx_req}, 32'h0);
    chk("reset_rw", {31'd0, rw}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    chk("reset_start_stop", {30'd0, start_det, stop_det}, 32'h0);
    chk("reset_lines", {30'd0, scl, sda}, 32'h3);
    rst = 1'b0;
    repeat (10) @(posedge clk_50);

    // Write 0xA5 to address 0x1B
    clr_counts();
    i2c_start();
    write_byte(8'h36, 1'b0, ack);
    chk("wr_addr_ack", {31'd0, ack}, 32'h0);
    chk("wr_busy", {31'd0, busy}, 32'h1);
    chk("wr_rw", {31'd0, rw}, 32'h0);
    exp_rx.push_back(8'hA5);
    write_byte(8'hA5, 1'b0, ack);
    chk("wr_data_ack", {31'd0, ack}, 32'h0);
    i2c_stop();
    chk("wr_rx_valid_count", n_rxv, 1);
    chk("wr_start_count", n_start, 1);
    chk("wr_stop_count", n_stop, 1);
    chk("wr_busy_after_stop", {31'd0, busy}, 32'h0);
    chk("wr_scl_never_driven", n_scl_drv, 0);

    // Address mismatch: 0x1C
    clr_counts();
    i2c_start();
    write_byte(8'h38, 1'b0, ack);
    chk("mm_addr_nack", {31'd0, ack}, 32'h1);
    write_byte(8'hFF, 1'b0, ack);
    chk("mm_data_nack", {31'd0, ack}, 32'h1);
    i2c_stop();
    chk("mm_sda_never_driven", n_sda_drv, 0);
    chk("mm_no_rx_valid", n_rxv, 0);
    chk("mm_busy_never", n_busy, 0);
    chk("mm_rx_data_held", {24'd0, rx_data}, 32'hA5);

    // Read 0x5A (ACK) then 0xC3 (NACK)
    clr_counts();
    tx_data = 8'h5A;
    i2c_start();
    write_byte(8'h37, 1'b0, ack);
    chk("rd_addr_ack", {31'd0, ack}, 32'h0);
    chk("rd_rw", {31'd0, rw}, 32'h1);
    chk("rd_busy", {31'd0, busy}, 32'h1);
    exp_rd.push_back(8'h5A);
    exp_rd.push_back(8'hC3);
    read_byte(8'hC3, 1'b0);
    read_byte(8'h00, 1'b1);
    chk("rd_busy_after_nack", {31'd0, busy}, 32'h0);
    i2c_stop();
    chk("rd_tx_req_count", n_txreq, 2);

    // Repeated START after 3 bits of a write byte
    clr_counts();
    i2c_start();
    write_byte(8'h36, 1'b0, ack);
    chk("rs_first_ack", {31'd0, ack}, 32'h0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    tx_data = 8'h81;
    i2c_start();
    write_byte(8'h37, 1'b0, ack);
    chk("rs_second_ack", {31'd0, ack}, 32'h0);
    chk("rs_rw", {31'd0, rw}, 32'h1);
    exp_rd.push_back(8'h81);
    read_byte(8'h00, 1'b1);
    i2c_stop();
    chk("rs_no_rx_valid", n_rxv, 0);
    chk("rs_start_count", n_start, 2);

    // Reset during bit 3 of a read of 0x00
    tx_data = 8'h00;
    i2c_start();
    write_byte(8'h37, 1'b0, ack);
    chk("rst_addr_ack", {31'd0, ack}, 32'h0);
    for (int i = 0; i < 4; i++) get_bit(b);
    m_sda = 1'b1; qwait();
    scl_high();
    repeat (Q / 2) @(posedge clk_50);
    @(negedge clk_50);
    chk("rst_bit3_driven_low", {31'd0, sda}, 32'h0);
    rst = 1'b1;
    @(negedge clk_50);
    chk("rst_sda_released", {31'd0, sda}, 32'h1);
    chk("rst_outputs", {rx_data, 3'd0, rx_valid, tx_req, rw, busy, start_det}, 32'h0);
    rst = 1'b0;
    m_scl = 1'b0; qwait();
    i2c_start();
    write_byte(8'h36, 1'b0, ack);
    chk("rst_after_addr_ack", {31'd0, ack}, 32'h0);
    exp_rx.push_back(8'h11);
    write_byte(8'h11, 1'b0, ack);
    chk("rst_after_data_ack", {31'd0, ack}, 32'h0);
    i2c_stop();

    // One-cycle SCL glitches inside every low phase
    clr_counts();
    i2c_start();
    write_byte(8'h36, 1'b1, ack);
    chk("gl_addr_ack", {31'd0, ack}, 32'h0);
    exp_rx.push_back(8'h96);
    write_byte(8'h96, 1'b1, ack);
    chk("gl_data_ack", {31'd0, ack}, 32'h0);
    i2c_stop();
    chk("gl_rx_valid_count", n_rxv, 1);

`ifdef I2C_SLAVE_STRETCH_EN
    clr_counts();
    tx_data = 8'h3C;
    i2c_start();
    write_byte(8'h37, 1'b0, ack);
    chk("st_addr_ack", {31'd0, ack}, 32'h0);
    exp_rd.push_back(8'h3C);
    read_byte(8'h00, 1'b1);
    i2c_stop();
    chk("st_scl_stretched", {31'd0, (n_scl_drv > 0 && n_scl_drv <= 50)}, 32'h1);
    chk("st_tx_req_count", n_txreq, 1);
`endif

    repeat (10) @(posedge clk_50);
    chk("pending_rx", exp_rx.size(), 0);
    chk("pending_rd", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
